// File: rtl/frame_decoder.sv
// Receive-side deframer for the slot-timed encoder byte stream.
// Skips the guard interval, samples one byte per slot, buffers the frame and drains it as a valid/ready burst.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a start strobe
// S_GUARD | counting leading guard cycles, din ignored
// S_SLOT  | timing byte slots, sampling din in the final cycle of each
// S_TAIL  | counting tail guard cycles after the end strobe
// S_DRAIN | presenting buffered bytes oldest first on the valid/ready port
module frame_decoder #(
   parameter int SIZE      = 20,
   parameter int LEFT_PAD  = 80,
   parameter int SLOT      = 8,
   parameter int RIGHT_PAD = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] din,
   input  logic       ind,
   output logic [7:0] dout,
   output logic       dout_valid,
   input  logic       dout_ready,
   output logic       dout_last,
   output logic [4:0] frame_len,
   output logic       frame_error
);

   localparam int CW   = 5;
   localparam int TMAX = (LEFT_PAD > RIGHT_PAD) ? ((LEFT_PAD > SLOT) ? LEFT_PAD : SLOT)
                                                : ((RIGHT_PAD > SLOT) ? RIGHT_PAD : SLOT);
   localparam int TW   = $clog2(TMAX);

   typedef enum logic [2:0] {S_IDLE, S_GUARD, S_SLOT, S_TAIL, S_DRAIN} state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [CW-1:0]   byte_cnt;
   logic [CW-1:0]   rd;
   logic [7:0]      buffer [SIZE];
   logic            wr_en;

   // A slot completing while the buffer is already full is an overflow, so it never writes.
   assign wr_en = (state == S_SLOT) && (timer == '0) && (byte_cnt != CW'(SIZE));

   always_ff @(posedge clk) begin
      if (wr_en) buffer[byte_cnt] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         timer       <= '0;
         byte_cnt    <= '0;
         rd          <= '0;
         dout        <= '0;
         dout_valid  <= 1'b0;
         dout_last   <= 1'b0;
         frame_len   <= '0;
         frame_error <= 1'b0;
      end else begin
         frame_error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ind) begin
                  state    <= S_GUARD;
                  timer    <= TW'(LEFT_PAD - 1);
                  byte_cnt <= '0;
               end
            end
            S_GUARD: begin
               if (ind) begin
                  frame_error <= 1'b1;
                  byte_cnt    <= '0;
                  state       <= S_IDLE;
               end else if (timer == '0) begin
                  state <= S_SLOT;
                  timer <= TW'(SLOT - 1);
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_SLOT: begin
               if (timer == '0) begin
                  if (byte_cnt == CW'(SIZE)) begin
                     frame_error <= 1'b1;
                     byte_cnt    <= '0;
                     state       <= S_IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + CW'(1);
                     if (ind) begin
                        state <= S_TAIL;
                        timer <= TW'(RIGHT_PAD - 1);
                     end else begin
                        timer <= TW'(SLOT - 1);
                     end
                  end
               end else if (ind) begin
                  frame_error <= 1'b1;
                  byte_cnt    <= '0;
                  state       <= S_IDLE;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_TAIL: begin
               if (ind) begin
                  frame_error <= 1'b1;
                  byte_cnt    <= '0;
                  state       <= S_IDLE;
               end else if (timer == '0) begin
                  state      <= S_DRAIN;
                  rd         <= '0;
                  dout       <= buffer[0];
                  dout_valid <= 1'b1;
                  dout_last  <= (byte_cnt == CW'(1));
                  frame_len  <= byte_cnt;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_DRAIN: begin
               // A strobe here is an overrun: flagged, but the drain carries on untouched.
               if (ind) frame_error <= 1'b1;
               if (dout_ready) begin
                  if (dout_last) begin
                     state      <= S_IDLE;
                     dout       <= '0;
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     frame_len  <= '0;
                  end else begin
                     rd        <= rd + CW'(1);
                     dout      <= buffer[rd + CW'(1)];
                     dout_last <= ((rd + CW'(2)) == byte_cnt);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/frame_decoder.md
# frame_decoder

Receive-side deframer for the slot-timed byte stream produced by the framing encoder. It:
- watches the encoder's 8-bit data bus and its one-cycle `ind` strobe;
- skips the leading guard interval and samples one byte per 8-cycle slot;
- checks frame timing and stores the frame;
- releases a good frame to downstream logic as a valid/ready byte burst, or discards a bad frame with an error pulse.

## Interface
- `SIZE`, 20, max bytes per frame (buffer depth)
- `LEFT_PAD`, 80, guard cycles between start strobe and first slot
- `SLOT`, 8, cycles per byte slot
- `RIGHT_PAD`, 16, tail guard cycles after end strobe
- `clk`  input  1  sole clock, all logic on posedge
- `reset_n`  input  1  reset, asynchronous, active-low
- `din`  input  8  slot-timed data from encoder
- `ind`  input  1  encoder state-change strobe (frame start / frame end)
- `dout`  output  8  frame byte, oldest first
- `dout_valid`  output  1  `dout` holds a byte
- `dout_ready`  input  1  downstream accepts byte when high with `dout_valid`
- `dout_last`  output  1  marks final byte of frame
- `frame_len`  output  5  byte count of the frame being drained
- `frame_error`  output  1  one-cycle pulse, frame discarded

## Operation
- All outputs are registered and reset to 0. On reset: state IDLE, counters 0, buffer contents don't-care.
- States are IDLE, GUARD, SLOT, TAIL, DRAIN.
- IDLE:
  - `ind`=1 → GUARD; clear byte count and slot counter.
- GUARD:
  - Counts `LEFT_PAD` cycles; `din` is ignored. After the last guard cycle → SLOT with slot count 0.
  - `ind`=1 in GUARD → error.
- SLOT:
  - The slot counter runs 0..`SLOT`-1. At count `SLOT`-1, `din` is written to `buffer[byte_cnt]` and `byte_cnt` increments.
  - `ind`=1 at count `SLOT`-1 → this byte is the last one. Store it, then go to TAIL.
  - `ind`=1 at any other count → error; the partial byte is not stored.
  - A slot completes with `ind`=0 while `byte_cnt` already equals `SIZE` → overflow error. Nothing is written past `SIZE`-1.
- TAIL:
  - Counts `RIGHT_PAD` cycles, then → DRAIN with read pointer 0.
  - `ind`=1 in TAIL → error.
- DRAIN:
  - `dout` = `buffer[rd]`, `dout_valid`=1, `frame_len` = `byte_cnt`.
  - `dout_last`=1 when `rd` = `byte_cnt`-1.
  - A handshake (`dout_valid` & `dout_ready`) advances `rd`. The handshake on the last byte → IDLE; `dout`, `dout_valid`, `dout_last` and `frame_len` return to 0 the next cycle.
  - `ind`=1 in DRAIN is an overrun: the new frame is not captured, `frame_error` pulses, and the drain continues unaffected.
- Error (any state except DRAIN): `frame_error`=1 for exactly one cycle, `byte_cnt` cleared, → IDLE. The strobe that caused the error is consumed and does not start a new frame.
- `dout` is 0 whenever `dout_valid`=0. Holding `dout_ready` low stalls the drain indefinitely with `dout`/`dout_last` stable.

## Timing
- Start strobe at cycle T.
- GUARD occupies T+1..T+`LEFT_PAD`.
- Slot k occupies T+`LEFT_PAD`+1+`SLOT`·k .. T+`LEFT_PAD`+`SLOT`·(k+1). Its byte is sampled in the final cycle of that window.
- End strobe at cycle E (final cycle of the last slot).
- TAIL occupies E+1..E+`RIGHT_PAD`.
- `dout_valid` rises at E+`RIGHT_PAD`+1 with byte 0. With `dout_ready` tied high, one byte is emitted per cycle.
- `frame_error` is asserted in the cycle after the offending `ind` sample.
- Reset mid-frame or mid-drain: immediate return to IDLE, all outputs 0, the frame is lost, and no error pulse is produced.
- Minimum frame is 1 byte. Maximum frame is `SIZE` bytes, where the end strobe falls in slot `SIZE`-1.

## Test plan
- Good frame, 3 bytes: `ind`@T, bytes 0xA5,0x3C,0xFF in slots 0..2, end `ind` at T+104. With `dout_ready`=1, expect `dout` = A5,3C,FF at T+121..T+123, `dout_last` only at T+123, `frame_len`=3, no `frame_error`.
- Backpressure: same frame with `dout_ready` low for 5 cycles after `dout_valid` rises. `dout` holds 0xA5 stable through the stall, then the sequence completes in order with no loss or duplication.
- Misaligned end: end `ind` at slot-1 count 3 → `frame_error` pulse next cycle, no `dout_valid`, back in IDLE. A following good 1-byte frame decodes correctly.
- Strobe in guard: `ind`@T then `ind`@T+40 → one `frame_error` pulse at T+41, no output.
- Overflow: `SIZE`=20, 21 slots without end `ind` → `frame_error` at the end of slot 20, buffer not written beyond index 19.
- Reset and overrun: assert `reset_n` low during slot 1 → all outputs 0 and next start accepted cleanly. A start `ind` during DRAIN → `frame_error` pulse while the current frame finishes draining intact.
